// File: rtl/pri_pkg.sv
// Shared types and helpers for the priority grant path.
// Holds the FSM encoding, one-hot helper and counter sizing.
package pri_pkg;

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      GAP
   } state_t;

   localparam int TIMEOUT_DEF = 16;
   localparam int CNT_W_DEF = $clog2(TIMEOUT_DEF);

   function automatic int cnt_width(input int t);
      cnt_width = $clog2(t);
   endfunction

   // Codes outside the line range give an all-zero vector.
   function automatic logic [31:0] onehot(
      input logic [31:0] code,
      input int n
   );
      logic [31:0] v;
      v = '0;
      if (code < 32'(n))
         v[code[4:0]] = 1'b1;
      onehot = v;
   endfunction

endpackage

// File: rtl/pri_pending_buf.sv
// One-entry holding register for the next code.
// load fills the slot, take empties it.
import pri_pkg::*;

module pri_pending_buf #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         take,
   input  logic [W-1:0] din,
   output logic         valid,
   output logic [W-1:0] data
);

   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         data  <= '0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= din;
      end else if (take) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/pri_decoder_grant.sv
// Turns encoder codes into a held, registered one-hot grant.
// A grant ends on ack or timeout and is always followed by one idle gap.
import pri_pkg::*;

module pri_decoder_grant #(
   parameter int N       = 4,
   parameter int W       = 2,
   parameter int TIMEOUT = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   input  logic [W-1:0] in_code,
   output logic         in_ready,
   output logic [N-1:0] grant,
   input  logic         ack,
   output logic         busy,
   output logic         timeout,
   output logic         bad_code
);

   localparam int CW = cnt_width(TIMEOUT);

   state_t         state;
   logic [CW-1:0]  cnt;
   logic [W-1:0]   code;
   logic           pvalid;
   logic [W-1:0]   pcode;
   logic           xfer;
   logic           good;
   logic           load;
   logic           take;

   assign in_ready = !pvalid & !rst;
   assign xfer     = in_valid & in_ready;
   assign good     = xfer & (32'(in_code) < 32'(N));
   assign load     = good & (state == GRANT);
   assign take     = (state == GAP) & pvalid;
   assign busy     = (state != IDLE) | pvalid;

   pri_pending_buf #(
      .W(W)
   ) u_pend (
      .clk  (clk),
      .rst  (rst),
      .load (load),
      .take (take),
      .din  (in_code),
      .valid(pvalid),
      .data (pcode)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         code     <= '0;
         grant    <= '0;
         timeout  <= 1'b0;
         bad_code <= 1'b0;
      end else begin
         timeout  <= 1'b0;
         bad_code <= xfer & ~good;
         unique case (state)
            IDLE: begin
               if (good) begin
                  code  <= in_code;
                  cnt   <= '0;
                  grant <= N'(onehot(32'(in_code), N));
                  state <= GRANT;
               end
            end
            GRANT: begin
               // ack beats a timeout landing on the same cycle
               if (ack || cnt == CW'(TIMEOUT - 1)) begin
                  timeout <= ~ack;
                  grant   <= '0;
                  state   <= GAP;
               end else begin
                  cnt   <= cnt + CW'(1);
                  grant <= N'(onehot(32'(code), N));
               end
            end
            GAP: begin
               if (pvalid) begin
                  code  <= pcode;
                  cnt   <= '0;
                  grant <= N'(onehot(32'(pcode), N));
                  state <= GRANT;
               end else if (good) begin
                  code  <= in_code;
                  cnt   <= '0;
                  grant <= N'(onehot(32'(in_code), N));
                  state <= GRANT;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pri_decoder_grant.sv
// Randomized scoreboard bench for pri_decoder_grant.
// Two instances (N=4 and N=3) share the stimulus.
module tb_pri_decoder_grant;

   localparam int TO = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       ack = 1'b0;
   logic [1:0] in_code = '0;

   logic       rdy0, busy0, to0, bad0;
   logic [3:0] g0;
   logic       rdy1, busy1, to1, bad1;
   logic [2:0] g1;

   int total = 0;
   int bad = 0;

   logic [7:0] q0[$];
   logic [7:0] q1[$];
   logic [7:0] e0, a0, e1, a1;

   int cur[2];
   int held[2];
   int pend[2];
   bit gap[2];

   always #5 clk = ~clk;

   pri_decoder_grant #(.N(4), .W(2), .TIMEOUT(TO)) dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_code(in_code),
      .in_ready(rdy0), .grant(g0), .ack(ack), .busy(busy0),
      .timeout(to0), .bad_code(bad0)
   );

   pri_decoder_grant #(.N(3), .W(2), .TIMEOUT(TO)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_code(in_code),
      .in_ready(rdy1), .grant(g1), .ack(ack), .busy(busy1),
      .timeout(to1), .bad_code(bad1)
   );

   // Reference: current owner, cycles held, waiting code, gap flag.
   task automatic model(input int k, input int n, output logic [7:0] e);
      bit xfer, good, to_p, bad_p;
      e = '0;
      if (rst) begin
         cur[k] = -1; pend[k] = -1; gap[k] = 0; held[k] = 0;
      end else begin
         xfer  = in_valid && (pend[k] < 0);
         good  = xfer && (int'(in_code) < n);
         bad_p = xfer && !good;
         to_p  = 0;
         if (cur[k] >= 0) begin
            if (good) pend[k] = int'(in_code);
            if (ack) begin
               cur[k] = -1; gap[k] = 1;
            end else if (held[k] == TO) begin
               cur[k] = -1; gap[k] = 1; to_p = 1;
            end else begin
               held[k]++;
            end
         end else if (gap[k]) begin
            gap[k] = 0;
            if (pend[k] >= 0) begin
               cur[k] = pend[k]; pend[k] = -1; held[k] = 1;
            end else if (good) begin
               cur[k] = int'(in_code); held[k] = 1;
            end
         end else if (good) begin
            cur[k] = int'(in_code); held[k] = 1;
         end
         e[3:0] = (cur[k] >= 0) ? 4'(1 << cur[k]) : 4'd0;
         e[4]   = to_p;
         e[5]   = bad_p;
         e[6]   = (cur[k] >= 0) || gap[k] || (pend[k] >= 0);
         e[7]   = (pend[k] < 0);
      end
   endtask

   task automatic cyc(input bit r, input bit v, input int c, input bit a);
      logic [7:0] e;
      @(negedge clk);
      #1;
      rst = r; in_valid = v; in_code = 2'(c); ack = a;
      @(posedge clk);
      model(0, 4, e);
      q0.push_back(e);
      model(1, 3, e);
      q1.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
   endtask

   always @(negedge clk) begin
      if (q0.size() > 0) begin
         e0 = q0.pop_front();
         a0 = {rdy0, busy0, bad0, to0, g0};
         total++;
         if (a0 !== e0) begin
            bad++;
            $display("FAIL n4 {rdy,busy,bad,to,grant} got=%b want=%b t=%0t",
                     a0, e0, $time);
         end
      end
      if (q1.size() > 0) begin
         e1 = q1.pop_front();
         a1 = {rdy1, busy1, bad1, to1, 1'b0, g1};
         total++;
         if (a1 !== e1) begin
            bad++;
            $display("FAIL n3 {rdy,busy,bad,to,grant} got=%b want=%b t=%0t",
                     a1, e1, $time);
         end
      end
   end

   initial begin
      for (int k = 0; k < 2; k++) begin
         cur[k] = -1; pend[k] = -1; gap[k] = 0; held[k] = 0;
      end
      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 0);
      // basic grant and ack
      cyc(0, 1, 2, 0);
      idle(3);
      cyc(0, 0, 0, 1);
      idle(3);
      // timeout
      cyc(0, 1, 1, 0);
      idle(20);
      // back-to-back with pending entry
      cyc(0, 1, 3, 0);
      cyc(0, 1, 0, 0);
      cyc(0, 1, 1, 0);
      cyc(0, 0, 0, 1);
      idle(4);
      cyc(0, 0, 0, 1);
      idle(3);
      // ack on the last grant cycle
      cyc(0, 1, 2, 0);
      idle(15);
      cyc(0, 0, 0, 1);
      idle(3);
      // reset with grant and pending outstanding
      cyc(0, 1, 1, 0);
      cyc(0, 1, 2, 0);
      cyc(1, 0, 0, 0);
      idle(20);
      // out-of-range code on the N=3 instance
      cyc(0, 1, 3, 0);
      idle(2);
      cyc(0, 1, 3, 1);
      idle(3);
      for (int i = 0; i < 3000; i++)
         cyc($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1,
             int'($urandom_range(0, 3)), $urandom_range(0, 11) == 0);
      @(negedge clk);
      #2;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pri_decoder_grant.md
Name: pri_decoder_grant

Overview:
- Receiving end of the priority-encoder path: consumes a {valid, code} pair from the encoder and drives a registered one-hot grant back to the requesting line.
- Each grant is held until that requester acknowledges it or a timeout expires.
- A one-entry pending buffer lets the encoder hand over the next code while a grant is outstanding.

Parameters:
- N, 4, number of request/grant lines.
- W, 2, code width; must satisfy 2**W >= N.
- TIMEOUT, 16, maximum cycles a grant is held without ack; must be >= 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  encoder has a valid code.
- in_code  input  W  binary index of winning request line.
- in_ready  output  1  block can accept a code this cycle.
- grant  output  N  one-hot grant, registered.
- ack  input  1  granted requester releases the grant.
- busy  output  1  grant outstanding or pending entry occupied.
- timeout  output  1  one-cycle pulse when a grant is revoked by timeout.
- bad_code  output  1  one-cycle pulse when an accepted code is >= N.

Behaviour:
- Reset: all of the following are 0 on the edge where rst=1, regardless of state: grant, timeout, bad_code, busy, hold counter, pending-valid, and the stored code. FSM goes to IDLE. Reset mid-grant drops the grant and the pending entry. in_ready=0 while rst=1.
- Transfer rule: a code transfers when in_valid & in_ready at a rising edge. in_ready is combinational and equals !pending_valid & !rst.
- Code check: an accepted code >= N is not stored. bad_code pulses on the next cycle. State is otherwise unchanged. Cannot occur when N = 2**W.
- FSM has three states: IDLE, GRANT, GAP.
- IDLE:
  - grant=0.
  - On a good transfer, latch the code and go to GRANT. grant[code]=1 from the next cycle, so latency is 1 cycle.
- GRANT:
  - grant holds one-hot of the stored code. The counter increments each cycle in GRANT, starting at 0 on the first grant cycle.
  - ack=1 goes to GAP. Ack counts in the first grant cycle.
  - If ack=0 and counter==TIMEOUT-1, go to GAP and pulse timeout in the first GAP cycle. The grant is therefore held for exactly TIMEOUT cycles.
  - Ack and timeout in the same cycle: ack wins, no timeout pulse.
  - A new transfer while in GRANT loads the pending entry (pending_valid=1).
- GAP:
  - Exactly one cycle with grant=0, which guarantees a release between consecutive grants, even to the same line.
  - If pending_valid, move the pending code to the stored code, clear pending, and go to GRANT.
  - Else, if a transfer happens in this cycle, load it directly as the stored code and go to GRANT.
  - Otherwise go to IDLE.
  - ack is ignored in GAP and IDLE.
- busy = (state != IDLE) | pending_valid.
- grant is never multi-hot. It is all zero except in GRANT.
- The counter uses clog2(TIMEOUT) bits, resets to 0 on entry to GRANT, and never wraps.

Decomposition:
- Shared package pri_pkg:
  - State enum {IDLE, GRANT, GAP}.
  - Function onehot(code, N).
  - Constant for counter width derived from TIMEOUT.
- Natural sub-module: pri_pending_buf, a one-entry valid/data holding register with load/take controls.
- The FSM, counter and grant register stay in the top.

Test Plan:
- Basic grant: rst 2 cycles, then in_code=2 with in_valid for 1 cycle. Expect grant=4'b0100 on the next cycle, held. Ack 3 cycles later gives grant=0 the following cycle, then IDLE with busy=0.
- Timeout: in_code=1, never ack. Expect grant=4'b0010 for exactly 16 cycles, then grant=0 with timeout=1 for one cycle.
- Back-to-back pending: code 3 accepted, then code 0 offered during GRANT. Expect in_ready to drop after the pending load. Ack gives 1 GAP cycle with grant=0, then grant=4'b0001 with no further input.
- Same-cycle ack at the timeout boundary: ack asserted on grant cycle 16. Expect no timeout pulse, a normal release, and GAP.
- Reset mid-operation: rst asserted while in GRANT with a pending entry. The next edge gives grant=0, busy=0, in_ready=1 after rst drops, and the pending code is never granted.
- bad_code with N=3, W=2: in_code=3 accepted. Expect bad_code pulse, grant stays 0, state stays IDLE.
